// File: rtl/dcm_prog_ctrl_pkg.sv
// Shared types and constants for the dcm programming sequencer.
package dcm_prog_ctrl_pkg;

  // Width of the dcm clock-select setting.
  localparam int PROG_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcm_prog_ctrl_edge_detector.sv
// Rising-edge detector for a level input already synchronous to clk.
// The pulse appears the cycle after the level is first seen high.
module edge_detector (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lvl_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  // Remember the previous level and register the 0->1 detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= lvl_i;
      rise_q <= lvl_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Button-driven sequencer that programs the dcm slow clock setting:
// select with up/down, apply to run setup/update/confirm with retries.
module dcm_prog_ctrl
  import dcm_prog_ctrl_pkg::*;
#(
  parameter int SETUP_CYC   = 4,
  parameter int UPD_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_apply,
  input  logic [PROG_W-1:0] prog_out,
  output logic [PROG_W-1:0] prog_in,
  output logic              update,
  output logic [PROG_W-1:0] sel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int SW = cnt_w(SETUP_CYC);
  localparam int UW = cnt_w(UPD_CYC);
  localparam int TW = cnt_w(TIMEOUT_CYC);
  localparam int RW = cnt_w(MAX_RETRY + 1);

  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYC - 1);
  localparam logic [UW-1:0] UPD_LAST   = UW'(UPD_CYC - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  logic up_rise, down_rise, apply_rise;
  logic ed_rst;

  state_t              state_q,     state_d;
  logic [PROG_W-1:0]   sel_q,       sel_d;
  logic [PROG_W-1:0]   target_q,    target_d;
  logic [PROG_W-1:0]   prog_in_q,   prog_in_d;
  logic                update_q,    update_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                err_q,       err_d;
  logic [SW-1:0]       setup_cnt_q, setup_cnt_d;
  logic [UW-1:0]       upd_cnt_q,   upd_cnt_d;
  logic [TW-1:0]       to_cnt_q,    to_cnt_d;
  logic [RW-1:0]       retry_q,     retry_d;

  assign ed_rst = ~rst_n;

  edge_detector u_ed_up (
    .clk_i  (clk),
    .rst_i  (ed_rst),
    .lvl_i  (btn_up),
    .rise_o (up_rise)
  );

  edge_detector u_ed_down (
    .clk_i  (clk),
    .rst_i  (ed_rst),
    .lvl_i  (btn_down),
    .rise_o (down_rise)
  );

  edge_detector u_ed_apply (
    .clk_i  (clk),
    .rst_i  (ed_rst),
    .lvl_i  (btn_apply),
    .rise_o (apply_rise)
  );

  // State, datapath and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      target_q    <= '0;
      prog_in_q   <= '0;
      update_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      setup_cnt_q <= '0;
      upd_cnt_q   <= '0;
      to_cnt_q    <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      target_q    <= target_d;
      prog_in_q   <= prog_in_d;
      update_q    <= update_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      setup_cnt_q <= setup_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
      to_cnt_q    <= to_cnt_d;
      retry_q     <= retry_d;
    end
  end

  // Next-state logic; update/done are computed one cycle early so they leave registered.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    target_d    = target_q;
    prog_in_d   = prog_in_q;
    update_d    = update_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    setup_cnt_d = setup_cnt_q;
    upd_cnt_d   = upd_cnt_q;
    to_cnt_d    = to_cnt_q;
    retry_d     = retry_q;

    // Selection stepping runs independently of the transaction; simultaneous presses cancel.
    if (up_rise && !down_rise) begin
      sel_d = sel_q + 1'b1;
    end else if (down_rise && !up_rise) begin
      sel_d = sel_q - 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (apply_rise) begin
          target_d    = sel_q;
          prog_in_d   = sel_q;
          retry_d     = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          setup_cnt_d = '0;
          state_d     = ST_ARM;
        end
      end

      ST_ARM: begin
        if (setup_cnt_q == SETUP_LAST) begin
          upd_cnt_d = '0;
          update_d  = 1'b1;
          state_d   = ST_PULSE;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end

      ST_PULSE: begin
        if (upd_cnt_q == UPD_LAST) begin
          update_d = 1'b0;
          to_cnt_d = '0;
          state_d  = ST_WAIT;
        end else begin
          upd_cnt_d = upd_cnt_q + 1'b1;
        end
      end

      ST_WAIT: begin
        // A match wins even on the cycle the timeout would fire.
        if (prog_out == target_q) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d   = retry_q + 1'b1;
            upd_cnt_d = '0;
            update_d  = 1'b1;
            state_d   = ST_PULSE;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        update_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  assign prog_in = prog_in_q;
  assign update  = update_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Self-checking bench for dcm_prog_ctrl with a reactive dcm stand-in.
module tb_dcm_prog_ctrl;

  localparam int S = 4;
  localparam int U = 2;
  localparam int T = 16;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_apply = 1'b0;
  logic [2:0] prog_out = 3'd0;
  logic [2:0] prog_in;
  logic       update;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic       err;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  logic [2:0] sel_m = 3'd0;
  int         err_m = 0;

  // Monitor state (written only by the monitor process)
  int   burst_q[$];
  int   cur_len = 0;
  int   bad_len = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   busy_rises = 0;
  int   busy_fall_cyc = -1;
  int   overlap = 0;
  int   resp_at = -1;
  logic upd_prev = 1'b0;
  logic busy_prev = 1'b0;

  // Responder settings (written only by the stimulus process)
  int         resp_burst = -1;
  int         resp_d = 1;
  logic [2:0] resp_val = 3'd0;

  dcm_prog_ctrl #(
    .SETUP_CYC   (S),
    .UPD_CYC     (U),
    .TIMEOUT_CYC (T),
    .MAX_RETRY   (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_apply (btn_apply),
    .prog_out  (prog_out),
    .prog_in   (prog_in),
    .update    (update),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle: update bursts, done pulses, busy edges.
  always @(negedge clk) begin
    if (update && done) overlap++;
    if (update) begin
      if (!upd_prev) begin
        burst_q.push_back(cyc);
        if (burst_q.size() == resp_burst) resp_at = cyc + resp_d;
      end
      cur_len++;
    end else if (upd_prev) begin
      if (cur_len != U) bad_len++;
      cur_len = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !busy_prev) busy_rises++;
    if (!busy && busy_prev) busy_fall_cyc = cyc;
    upd_prev  = update;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the dcm stand-in reports the new setting when scheduled.
  task automatic tick;
    @(posedge clk);
    #1;
    if (cyc == resp_at) prog_out = resp_val;
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up   = up;
    btn_down = dn;
    tick;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick;
    tick;
    if (up && !dn) sel_m = sel_m + 3'd1;
    else if (dn && !up) sel_m = sel_m - 3'd1;
  endtask

  // One apply transaction. rb: burst number the dcm answers (0 = never),
  // d: cycles after that burst's first update before prog_out shows target,
  // same: prog_out already equals target, ign: extra apply+up press while busy.
  task automatic run_txn(input string tag, input int mv, input int rb, input int d,
                         input bit same, input bit ign);
    int k, nb, m, u1, ub, ulast, exp_done, exp_done_cyc, exp_fall, end_cyc;
    int b0, dc0, br0, bl0;
    logic [2:0] tgt;
    for (int i = 0; i < mv; i++) begin
      if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0);
      else press(1'b0, 1'b1);
    end
    tgt = sel_m;
    chk({tag, " err_before"}, int'(err), err_m);
    if (same) prog_out = tgt;
    else prog_out = tgt + 3'($urandom_range(1, 7));
    b0  = burst_q.size();
    dc0 = done_cnt;
    br0 = busy_rises;
    bl0 = bad_len;
    resp_val   = tgt;
    resp_d     = d;
    resp_burst = (rb == 0) ? -1 : b0 + rb;

    k = cyc;
    btn_apply = 1'b1;
    tick;
    btn_apply = 1'b0;
    tick;
    chk({tag, " prog_in_early"}, int'(prog_in), int'(tgt));
    chk({tag, " busy_early"}, int'(busy), 1);
    chk({tag, " err_cleared"}, int'(err), 0);
    if (ign) begin
      btn_apply = 1'b1;
      btn_up    = 1'b1;
      tick;
      btn_apply = 1'b0;
      btn_up    = 1'b0;
      sel_m     = sel_m + 3'd1;
    end

    // Reference timeline: first update SETUP+1 after the apply-rise cycle,
    // each failed attempt costs UPD+TIMEOUT cycles before the next burst.
    u1 = k + S + 2;
    exp_done_cyc = -1;
    if (same) begin
      nb = 1;
      exp_done = 1;
      m = u1 + U;
    end else if (rb >= 1 && rb <= R + 1) begin
      nb = rb;
      ub = u1 + (rb - 1) * (U + T);
      m = (ub + d > ub + U) ? ub + d : ub + U;
      exp_done = 1;
    end else begin
      nb = R + 1;
      exp_done = 0;
      m = 0;
    end
    ulast = u1 + (nb - 1) * (U + T);
    if (exp_done == 1) begin
      exp_done_cyc = m + 1;
      exp_fall = m + 2;
    end else begin
      exp_fall = ulast + U + T + 1;
    end
    end_cyc = exp_fall + S + 6;
    while (cyc < end_cyc) tick;

    chk({tag, " bursts"}, burst_q.size() - b0, nb);
    if (burst_q.size() > b0) chk({tag, " first_update_cyc"}, burst_q[b0], u1);
    if (burst_q.size() >= b0 + nb) chk({tag, " last_update_cyc"}, burst_q[b0 + nb - 1], ulast);
    chk({tag, " burst_len_bad"}, bad_len - bl0, 0);
    chk({tag, " done_pulses"}, done_cnt - dc0, exp_done);
    if (exp_done == 1) chk({tag, " done_cyc"}, done_cyc, exp_done_cyc);
    chk({tag, " busy_fall_cyc"}, busy_fall_cyc, exp_fall);
    chk({tag, " busy_end"}, int'(busy), 0);
    chk({tag, " busy_starts"}, busy_rises - br0, 1);
    chk({tag, " err_end"}, int'(err), 1 - exp_done);
    chk({tag, " upd_done_overlap"}, overlap, 0);
    chk({tag, " sel"}, int'(sel), int'(sel_m));
    chk({tag, " prog_in_hold"}, int'(prog_in), int'(tgt));
    err_m = 1 - exp_done;
  endtask

  initial begin
    int n, b0;
    bit up, dn;

    // Reset values
    rst_n = 1'b0;
    tick;
    tick;
    chk("rst prog_in", int'(prog_in), 0);
    chk("rst sel", int'(sel), 0);
    chk("rst update", int'(update), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst err", int'(err), 0);
    rst_n = 1'b1;
    tick;

    // Selection stepping and wrap
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("sel 3x up", int'(sel), 3);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("sel back to 0", int'(sel), 0);
    press(1'b0, 1'b1);
    chk("sel 0-1 wraps", int'(sel), 7);
    press(1'b1, 1'b1);
    chk("sel up+down", int'(sel), 7);
    press(1'b1, 1'b0);
    chk("sel 7+1 wraps", int'(sel), 0);
    for (int i = 0; i < 8; i++) begin
      up = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
      press(up, dn);
      chk("sel random", int'(sel), int'(sel_m));
    end

    // Happy path on selection 5, answer three cycles after first update
    n = 0;
    while (sel_m != 3'd5 && n < 8) begin
      press(1'b1, 1'b0);
      n++;
    end
    chk("sel at 5", int'(sel), 5);
    run_txn("happy", 0, 1, 3, 1'b0, 1'b0);

    // Answer only the second burst
    run_txn("retry", 2, 2, $urandom_range(1, U + T - 1), 1'b0, 1'b0);

    // Never answer: all attempts exhausted
    run_txn("exhaust", 1, 0, 1, 1'b0, 1'b0);

    // Successful apply clears err
    run_txn("recover", 1, 1, 4, 1'b0, 1'b0);

    // Apply during busy is ignored; sel still steps while busy
    run_txn("ignore", 0, 1, 5, 1'b0, 1'b1);

    // Target already equals prog_out: full sequence, minimum latency
    run_txn("same", 2, 0, 1, 1'b1, 1'b0);

    // Match on the final timeout cycle counts as a match
    run_txn("edge_match", 1, 1, U + T - 1, 1'b0, 1'b0);

    // Randomised transactions
    for (int i = 0; i < 6; i++) begin
      run_txn("rand", $urandom_range(0, 3), $urandom_range(0, R + 1),
              $urandom_range(1, U + T - 1), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an update burst
    prog_out   = sel_m + 3'd1;
    resp_burst = -1;
    btn_apply  = 1'b1;
    tick;
    btn_apply = 1'b0;
    n = 0;
    while (!update && n < 40) begin
      tick;
      n++;
    end
    chk("midrst reached pulse", int'(update), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst update", int'(update), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst prog_in", int'(prog_in), 0);
    chk("midrst sel", int'(sel), 0);
    chk("midrst done", int'(done), 0);
    chk("midrst err", int'(err), 0);
    tick;
    tick;
    #2;
    rst_n = 1'b1;
    sel_m = 3'd0;
    err_m = 0;
    b0 = burst_q.size();
    repeat (S + U + 6) tick;
    chk("postrst no update", burst_q.size() - b0, 0);
    chk("postrst busy", int'(busy), 0);
    chk("postrst sel", int'(sel), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
